// File: rtl/j1_io_uart.sv
// Memory-mapped 8N1 UART for the J1 IO bus: TX serialiser, RX deserialiser
// feeding a small FIFO, and a STATUS/DIVISOR register pair.
module j1_io_uart #(
  parameter logic [15:0] BASE_ADDR  = 16'h6000,
  parameter int          CLK_FREQ   = 50000000,
  parameter int          BAUD       = 115200,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_i,
  input  logic        io_rd_i,
  input  logic        io_wr_i,
  input  logic [15:0] io_addr_i,
  input  logic [15:0] io_wdata_i,
  output logic [15:0] io_rdata_o,
  input  logic        uart_rx_i,
  output logic        uart_tx_o
);

  localparam int              AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [15:0]     RST_DIV  = 16'(CLK_FREQ / BAUD);
  localparam logic [AW:0]     CNT_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  function automatic logic [15:0] clamp_div(input logic [15:0] v);
    return (v < 16'd2) ? 16'd2 : v;
  endfunction

  // Address decode and strobes
  logic        sel_s;
  logic [2:0]  off_s;
  logic        wr_tx_s;
  logic        wr_st_s;
  logic        wr_div_s;
  logic        pop_s;
  logic        unused_s;

  assign sel_s    = (io_addr_i[15:4] == BASE_ADDR[15:4]);
  assign off_s    = io_addr_i[3:1];
  assign wr_tx_s  = io_wr_i & sel_s & (off_s == 3'd0);
  assign wr_st_s  = io_wr_i & sel_s & (off_s == 3'd1);
  assign wr_div_s = io_wr_i & sel_s & (off_s == 3'd2);
  assign unused_s = io_addr_i[0];

  logic [15:0]  div_r;

  uart_state_t  tx_state_r;
  logic [15:0]  tx_cnt_r;
  logic [2:0]   tx_bit_r;
  logic [7:0]   tx_shift_r;
  logic [15:0]  tx_div_r;
  logic         tx_line_r;
  logic         tx_busy_s;

  logic         rx_meta_r;
  logic         rx_sync_r;
  logic         rx_prev_r;
  uart_state_t  rx_state_r;
  logic [15:0]  rx_cnt_r;
  logic [2:0]   rx_bit_r;
  logic [7:0]   rx_shift_r;
  logic [15:0]  rx_div_r;
  logic         rx_brk_r;
  logic         rx_push_r;
  logic [7:0]   rx_data_r;
  logic         rx_ferr_r;

  logic [7:0]   fifo_mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]  fifo_cnt_r;
  logic         empty_s;
  logic         full_s;
  logic         push_ok_s;

  logic         tx_drop_r;
  logic         rx_ovr_r;
  logic         frame_err_r;
  logic [15:0]  status_s;
  logic [15:0]  rdata_s;

  assign tx_busy_s = (tx_state_r != ST_IDLE);
  assign uart_tx_o = tx_line_r;
  assign empty_s   = (fifo_cnt_r == '0);
  assign full_s    = (fifo_cnt_r == CNT_FULL);
  assign pop_s     = io_rd_i & sel_s & (off_s == 3'd0) & ~empty_s;
  // A push into a full FIFO still lands if a pop frees the slot on the same edge.
  assign push_ok_s = rx_push_r & (~full_s | pop_s);

  // Baud divisor register
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      div_r <= RST_DIV;
    end else if (wr_div_s) begin
      div_r <= clamp_div(io_wdata_i);
    end
  end

  // TX serialiser; the divisor is frozen for the duration of a frame
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      tx_state_r <= ST_IDLE;
      tx_cnt_r   <= 16'd0;
      tx_bit_r   <= 3'd0;
      tx_shift_r <= 8'd0;
      tx_div_r   <= RST_DIV;
      tx_line_r  <= 1'b1;
    end else begin
      case (tx_state_r)
        ST_IDLE: begin
          if (wr_tx_s) begin
            tx_shift_r <= io_wdata_i[7:0];
            tx_div_r   <= div_r;
            tx_cnt_r   <= 16'd0;
            tx_bit_r   <= 3'd0;
            tx_line_r  <= 1'b0;
            tx_state_r <= ST_START;
          end
        end
        ST_START: begin
          if (tx_cnt_r == tx_div_r - 16'd1) begin
            tx_cnt_r   <= 16'd0;
            tx_line_r  <= tx_shift_r[0];
            tx_state_r <= ST_DATA;
          end else begin
            tx_cnt_r <= tx_cnt_r + 16'd1;
          end
        end
        ST_DATA: begin
          if (tx_cnt_r == tx_div_r - 16'd1) begin
            tx_cnt_r <= 16'd0;
            if (tx_bit_r == 3'd7) begin
              tx_line_r  <= 1'b1;
              tx_state_r <= ST_STOP;
            end else begin
              tx_bit_r   <= tx_bit_r + 3'd1;
              tx_line_r  <= tx_shift_r[1];
              tx_shift_r <= {1'b0, tx_shift_r[7:1]};
            end
          end else begin
            tx_cnt_r <= tx_cnt_r + 16'd1;
          end
        end
        ST_STOP: begin
          if (tx_cnt_r == tx_div_r - 16'd1) begin
            tx_cnt_r   <= 16'd0;
            tx_state_r <= ST_IDLE;
          end else begin
            tx_cnt_r <= tx_cnt_r + 16'd1;
          end
        end
        default: begin
          tx_state_r <= ST_IDLE;
          tx_line_r  <= 1'b1;
        end
      endcase
    end
  end

  // RX line synchroniser plus one delayed copy for falling-edge detection
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= uart_rx_i;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // RX deserialiser; after a bad stop bit it parks in STOP until the line idles high
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      rx_state_r <= ST_IDLE;
      rx_cnt_r   <= 16'd0;
      rx_bit_r   <= 3'd0;
      rx_shift_r <= 8'd0;
      rx_div_r   <= RST_DIV;
      rx_brk_r   <= 1'b0;
      rx_push_r  <= 1'b0;
      rx_data_r  <= 8'd0;
      rx_ferr_r  <= 1'b0;
    end else begin
      rx_push_r <= 1'b0;
      rx_ferr_r <= 1'b0;
      case (rx_state_r)
        ST_IDLE: begin
          if (rx_prev_r & ~rx_sync_r) begin
            rx_cnt_r   <= 16'd0;
            rx_div_r   <= div_r;
            rx_state_r <= ST_START;
          end
        end
        ST_START: begin
          if (rx_cnt_r == (rx_div_r >> 1) - 16'd1) begin
            rx_cnt_r <= 16'd0;
            rx_bit_r <= 3'd0;
            rx_state_r <= rx_sync_r ? ST_IDLE : ST_DATA;
          end else begin
            rx_cnt_r <= rx_cnt_r + 16'd1;
          end
        end
        ST_DATA: begin
          if (rx_cnt_r == rx_div_r - 16'd1) begin
            rx_cnt_r   <= 16'd0;
            rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
            if (rx_bit_r == 3'd7) begin
              rx_state_r <= ST_STOP;
            end else begin
              rx_bit_r <= rx_bit_r + 3'd1;
            end
          end else begin
            rx_cnt_r <= rx_cnt_r + 16'd1;
          end
        end
        ST_STOP: begin
          if (rx_brk_r) begin
            if (rx_sync_r) begin
              rx_brk_r   <= 1'b0;
              rx_state_r <= ST_IDLE;
            end
          end else if (rx_cnt_r == rx_div_r - 16'd1) begin
            rx_cnt_r <= 16'd0;
            if (rx_sync_r) begin
              rx_push_r  <= 1'b1;
              rx_data_r  <= rx_shift_r;
              rx_state_r <= ST_IDLE;
            end else begin
              rx_ferr_r <= 1'b1;
              rx_brk_r  <= 1'b1;
            end
          end else begin
            rx_cnt_r <= rx_cnt_r + 16'd1;
          end
        end
        default: begin
          rx_state_r <= ST_IDLE;
          rx_brk_r   <= 1'b0;
        end
      endcase
    end
  end

  // RX FIFO pointers and occupancy
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      fifo_cnt_r <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({push_ok_s, pop_s})
        2'b10:   fifo_cnt_r <= fifo_cnt_r + 1'b1;
        2'b01:   fifo_cnt_r <= fifo_cnt_r - 1'b1;
        default: fifo_cnt_r <= fifo_cnt_r;
      endcase
    end
  end

  // RX FIFO storage
  always_ff @(posedge sys_clk_i) begin
    if (push_ok_s) begin
      fifo_mem_r[wr_ptr_r] <= rx_data_r;
    end
  end

  // Sticky error flags: a new event wins over a same-cycle write-one-to-clear
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      rx_ovr_r    <= 1'b0;
      tx_drop_r   <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      rx_ovr_r    <= (rx_ovr_r & ~(wr_st_s & io_wdata_i[3])) | (rx_push_r & full_s & ~pop_s);
      tx_drop_r   <= (tx_drop_r & ~(wr_st_s & io_wdata_i[4])) | (wr_tx_s & tx_busy_s);
      frame_err_r <= (frame_err_r & ~(wr_st_s & io_wdata_i[5])) | rx_ferr_r;
    end
  end

  assign status_s = {10'b0, frame_err_r, tx_drop_r, rx_ovr_r, full_s, ~empty_s, tx_busy_s};

  // Combinational read mux; the CPU samples it on the edge its read strobe is high
  always_comb begin
    rdata_s = 16'h0000;
    if (sel_s) begin
      case (off_s)
        3'd0:    rdata_s = empty_s ? 16'h0000 : {8'h00, fifo_mem_r[rd_ptr_r]};
        3'd1:    rdata_s = status_s;
        3'd2:    rdata_s = div_r;
        default: rdata_s = 16'h0000;
      endcase
    end else begin
      rdata_s = 16'h0000;
    end
  end

  assign io_rdata_o = rdata_s;

endmodule

// File: tb/tb_j1_io_uart.sv
// Directed self-checking bench for j1_io_uart: TX framing, RX loopback,
// FIFO overrun, address decode, busy drop, framing error and mid-frame reset.
module tb_j1_io_uart;

  localparam logic [15:0] A_DATA = 16'h6000;
  localparam logic [15:0] A_STAT = 16'h6002;
  localparam logic [15:0] A_DIV  = 16'h6004;
  localparam logic [15:0] RST_DIV = 16'd434;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        io_rd = 1'b0;
  logic        io_wr = 1'b0;
  logic [15:0] io_addr = 16'h0000;
  logic [15:0] io_wdata = 16'h0000;
  logic [15:0] io_rdata;
  logic        rx_drv = 1'b1;
  logic        loop = 1'b0;
  logic        rx_line;
  logic        tx;

  int checks = 0;
  int errors = 0;

  assign rx_line = loop ? tx : rx_drv;

  always #5 clk = ~clk;

  j1_io_uart #(
    .BASE_ADDR(16'h6000), .CLK_FREQ(50000000), .BAUD(115200), .FIFO_DEPTH(8)
  ) dut (
    .sys_clk_i(clk), .sys_rst_i(rst), .io_rd_i(io_rd), .io_wr_i(io_wr),
    .io_addr_i(io_addr), .io_wdata_i(io_wdata), .io_rdata_o(io_rdata),
    .uart_rx_i(rx_line), .uart_tx_o(tx)
  );

  task automatic io_write(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    io_addr = a; io_wdata = d; io_wr = 1'b1;
    @(negedge clk);
    io_wr = 1'b0; io_addr = 16'h0000;
  endtask

  task automatic io_read(input logic [15:0] a, output logic [15:0] d);
    @(negedge clk);
    io_addr = a; io_rd = 1'b1;
    #1 d = io_rdata;
    @(negedge clk);
    io_rd = 1'b0; io_addr = 16'h0000;
  endtask

  // Drives one 8N1 frame at divisor 4 followed by idle time.
  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (4) @(negedge clk);
    end
    rx_drv = stop_bit;
    repeat (4) @(negedge clk);
    rx_drv = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [15:0] d;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
    io_read(A_STAT, d);
    checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL reset_status: got %h expected 0000", d); end
    io_read(A_DIV, d);
    checks++;
    if (d !== RST_DIV) begin errors++; $display("FAIL reset_div: got %h expected %h", d, RST_DIV); end
    io_read(16'h0004, d);
    checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL unsel_read: got %h expected 0000", d); end
  endtask

  task automatic test_tx_frame;
    logic [15:0] d;
    logic [9:0]  pat;
    pat = {1'b1, 8'hA5, 1'b0};
    io_write(A_DIV, 16'h0004);
    io_read(A_DIV, d);
    checks++;
    if (d !== 16'h0004) begin errors++; $display("FAIL div_write: got %h expected 0004", d); end
    io_write(A_DATA, 16'h00A5);
    io_addr = A_STAT; io_rd = 1'b1;
    for (int k = 0; k < 41; k++) begin
      #1;
      checks++;
      if (tx !== ((k < 40) ? pat[k / 4] : 1'b1)) begin
        errors++; $display("FAIL tx_bit k=%0d: got %b expected %b", k, tx, (k < 40) ? pat[k / 4] : 1'b1);
      end
      checks++;
      if (io_rdata[0] !== (k < 40)) begin
        errors++; $display("FAIL tx_busy k=%0d: got %b expected %b", k, io_rdata[0], (k < 40));
      end
      @(negedge clk);
    end
    io_rd = 1'b0; io_addr = 16'h0000;
  endtask

  task automatic test_loopback;
    logic [15:0] d;
    loop = 1'b1;
    io_write(A_DATA, 16'h003C);
    repeat (60) @(negedge clk);
    io_read(A_STAT, d);
    checks++;
    if (d !== 16'h0002) begin errors++; $display("FAIL loop_status: got %h expected 0002", d); end
    io_read(A_DATA, d);
    checks++;
    if (d !== 16'h003C) begin errors++; $display("FAIL loop_data: got %h expected 003c", d); end
    io_read(A_STAT, d);
    checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL loop_status_after: got %h expected 0000", d); end
    loop = 1'b0;
  endtask

  task automatic test_overrun;
    logic [15:0] d;
    for (int i = 1; i <= 9; i++) send_rx(8'(i), 1'b1);
    io_read(A_STAT, d);
    checks++;
    if (d !== 16'h000E) begin errors++; $display("FAIL ovr_status: got %h expected 000e", d); end
    for (int i = 1; i <= 8; i++) begin
      io_read(A_DATA, d);
      checks++;
      if (d !== 16'(i)) begin errors++; $display("FAIL ovr_read%0d: got %h expected %h", i, d, 16'(i)); end
    end
    io_read(A_STAT, d);
    checks++;
    if (d !== 16'h0008) begin errors++; $display("FAIL ovr_drained: got %h expected 0008", d); end
    io_write(A_STAT, 16'h0008);
    io_read(A_STAT, d);
    checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL ovr_w1c: got %h expected 0000", d); end
  endtask

  task automatic test_empty_decode;
    logic [15:0] d;
    io_read(A_DATA, d);
    checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL empty_read: got %h expected 0000", d); end
    send_rx(8'h77, 1'b1);
    io_read(A_DATA, d);
    checks++;
    if (d !== 16'h0077) begin errors++; $display("FAIL after_empty_read: got %h expected 0077", d); end
    io_read(A_STAT, d);
    checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL after_empty_status: got %h expected 0000", d); end
    io_write(16'h0000, 16'h0055);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (tx !== 1'b1) begin errors++; $display("FAIL ram_store_tx k=%0d: got %b expected 1", k, tx); end
      @(negedge clk);
    end
    io_read(A_STAT, d);
    checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL ram_store_status: got %h expected 0000", d); end
  endtask

  task automatic test_busy_drop;
    logic [15:0] d;
    logic [9:0]  pat;
    pat = {1'b1, 8'h81, 1'b0};
    io_write(A_DATA, 16'h0081);
    io_write(A_DATA, 16'h007E);
    io_read(A_STAT, d);
    checks++;
    if (d !== 16'h0011) begin errors++; $display("FAIL drop_status: got %h expected 0011", d); end
    for (int k = 4; k < 60; k++) begin
      checks++;
      if (tx !== ((k < 40) ? pat[k / 4] : 1'b1)) begin
        errors++; $display("FAIL drop_tx k=%0d: got %b expected %b", k, tx, (k < 40) ? pat[k / 4] : 1'b1);
      end
      @(negedge clk);
    end
    io_read(A_STAT, d);
    checks++;
    if (d !== 16'h0010) begin errors++; $display("FAIL drop_idle_status: got %h expected 0010", d); end
    io_write(A_STAT, 16'h0010);
    io_read(A_STAT, d);
    checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL drop_w1c: got %h expected 0000", d); end
  endtask

  task automatic test_framing;
    logic [15:0] d;
    send_rx(8'h11, 1'b1);
    send_rx(8'h5A, 1'b0);
    io_read(A_STAT, d);
    checks++;
    if (d !== 16'h0022) begin errors++; $display("FAIL ferr_status: got %h expected 0022", d); end
    io_read(A_DATA, d);
    checks++;
    if (d !== 16'h0011) begin errors++; $display("FAIL ferr_good_byte: got %h expected 0011", d); end
    io_read(A_DATA, d);
    checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL ferr_no_push: got %h expected 0000", d); end
    io_write(A_STAT, 16'h0020);
    send_rx(8'h33, 1'b1);
    io_read(A_STAT, d);
    checks++;
    if (d !== 16'h0002) begin errors++; $display("FAIL ferr_recover: got %h expected 0002", d); end
    io_read(A_DATA, d);
    checks++;
    if (d !== 16'h0033) begin errors++; $display("FAIL ferr_recover_byte: got %h expected 0033", d); end
  endtask

  task automatic test_reset_mid;
    logic [15:0] d;
    send_rx(8'h21, 1'b1);
    send_rx(8'h22, 1'b1);
    io_read(A_STAT, d);
    checks++;
    if (d !== 16'h0002) begin errors++; $display("FAIL pre_reset_status: got %h expected 0002", d); end
    io_write(A_DATA, 16'h00F0);
    repeat (17) @(negedge clk);
    checks++;
    if (tx !== 1'b0) begin errors++; $display("FAIL pre_reset_d3: got %b expected 0", tx); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL mid_reset_tx: got %b expected 1", tx); end
    rst = 1'b0;
    io_read(A_STAT, d);
    checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL mid_reset_status: got %h expected 0000", d); end
    io_read(A_DIV, d);
    checks++;
    if (d !== RST_DIV) begin errors++; $display("FAIL mid_reset_div: got %h expected %h", d, RST_DIV); end
    io_read(A_DATA, d);
    checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL mid_reset_fifo: got %h expected 0000", d); end
  endtask

  initial begin
    test_reset();
    test_tx_frame();
    test_loopback();
    test_overrun();
    test_empty_decode();
    test_busy_drop();
    test_framing();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/j1_io_uart.md
Name: j1_io_uart

Overview:
- Memory-mapped UART responder on the J1 CPU IO bus.
- Sits on the far side of the CPU's io_rd/io_wr/io_addr/io_dout/io_din interface.
- Decodes its own address window and serialises bytes written by firmware (8N1, LSB first).
- Deserialises incoming bytes into an RX FIFO, which firmware reads back through io_din.

Parameters:
- BASE_ADDR, 16'h6000, IO window base; bits [15:4] compared. Must have bits [15:14] != 0.
- CLK_FREQ, 50000000, sys_clk_i frequency in Hz.
- BAUD, 115200, reset baud rate. Reset divisor is CLK_FREQ/BAUD, integer truncated.
- FIFO_DEPTH, 8, RX FIFO entries. Power of 2, minimum 2.

Ports:
- sys_clk_i  in  1  system clock, all logic on rising edge
- sys_rst_i  in  1  synchronous reset, active high
- io_rd_i  in  1  CPU read strobe; connects to CPU io_rd
- io_wr_i  in  1  CPU write strobe; connects to CPU io_wr. Also asserted for RAM stores, so address decode is mandatory.
- io_addr_i  in  16  CPU address; connects to CPU io_addr
- io_wdata_i  in  16  CPU write data; connects to CPU io_dout
- io_rdata_o  out  16  read data; connects to CPU io_din
- uart_rx_i  in  1  serial input, asynchronous
- uart_tx_o  out  1  serial output

Behaviour:
- Address decode: sel = (io_addr_i[15:4] == BASE_ADDR[15:4]); off = io_addr_i[3:1].
- Register map:
  - off 0, write: TXDATA. Write launches a frame with io_wdata_i[7:0].
  - off 0, read: RXDATA. Returns {8'h00, FIFO head}. Returns 16'h0000 when FIFO is empty.
  - off 1, read: STATUS = {10'b0, frame_err, tx_drop, rx_ovr, rx_full, rx_avail, tx_busy} (bits 5..0).
  - off 1, write: W1C on bits 3..5.
  - off 2: DIVISOR, read/write, 16 bits. A written value < 2 is stored as 2.
  - Other offsets: read 0, writes ignored.
- Read timing:
  - io_rdata_o is combinational from io_addr_i and current state, valid in the same cycle io_rd_i is high. The CPU captures io_din at that edge.
  - io_rdata_o is 0 when not sel.
  - Side effect: at the edge where io_rd_i & sel & off==0 & !empty, the FIFO head is popped.
- Write timing: sampled at the rising edge where io_wr_i & sel; single-cycle strobe.
- TX path:
  - FSM states IDLE, START, DATA, STOP. Bit counter 0..7, baud counter 0..DIV-1.
  - A TXDATA write in IDLE latches the byte. uart_tx_o goes 0 on the following cycle.
  - Each bit is held exactly DIV cycles: start=0, d0..d7, stop=1. Then IDLE.
  - tx_busy = (state != IDLE). It deasserts on the cycle after the stop bit's last cycle.
  - A TXDATA write while busy is discarded and sets sticky tx_drop.
  - A DIVISOR write mid-frame is used from the next frame (the divisor is latched at frame start).
- RX path:
  - uart_rx_i passes through a 2-flop synchroniser.
  - FSM states IDLE, START, DATA, STOP.
  - A falling edge in IDLE enters START. At DIV/2 the line is re-checked; if it is high, this is a false start and the FSM returns to IDLE.
  - Data bits are then sampled every DIV cycles, LSB first. The stop bit is sampled DIV cycles after d7.
  - Stop = 1: push the byte. Stop = 0: discard the byte, set sticky frame_err, return to IDLE only after the line is seen high.
- FIFO:
  - rx_avail = !empty; rx_full = (count == FIFO_DEPTH).
  - A push when full is dropped and sets sticky rx_ovr.
  - Simultaneous push and pop: both take effect, count is unchanged; this is legal even when full.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset values:
  - uart_tx_o=1; both FSMs IDLE; FIFO empty; all sticky bits 0; DIVISOR = CLK_FREQ/BAUD.
  - io_rdata_o follows the decode rules (0 unless reading an active register).
- Reset mid-frame: on the next edge uart_tx_o=1, the partial RX byte is lost, the FIFO is flushed, and sticky bits are cleared.
- Writes and reads whose address is outside the window have no effect. This includes RAM stores, where the CPU's io_wr is high with io_addr[15:14]==0.

Test Plan:
- TX frame: DIVISOR=4, write TXDATA 0x00A5 -> starting the cycle after the write, uart_tx_o = 0, then 1,0,1,0,0,1,0,1, then 1, each held 4 cycles; tx_busy=1 for 40 cycles.
- RX loopback: tie tx to rx, DIV=4, send 0x3C -> STATUS=0x0002, RXDATA read returns 0x003C, following STATUS=0x0000.
- Overrun: inject 9 frames 0x01..0x09 with FIFO_DEPTH=8 and no reads -> STATUS bits rx_full=1 and rx_ovr=1; 8 reads return 0x01..0x08; write STATUS 0x0008 clears rx_ovr.
- Read empty / decode: RXDATA read with empty FIFO returns 0x0000, no pointer change; io_wr with io_addr=0x0000, data 0x55 -> no TX activity.
- Busy drop and framing: second TXDATA write during a frame -> tx_drop=1, only the first byte transmitted. An RX frame with stop=0 -> frame_err=1, FIFO count unchanged.
- Reset mid-frame: assert sys_rst_i during d3 of TX with 2 bytes in the FIFO -> next cycle uart_tx_o=1, STATUS=0x0000, DIVISOR reads CLK_FREQ/BAUD.
